// File: rtl/mmio_uart_ctrl_pkg.sv
// Shared register map, AXI response codes and access-engine types for the
// MMIO UART transmit controller.
package mmio_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_WRESP = 2'd2,
    ST_RDATA = 2'd3
  } eng_state_e;

  typedef enum logic [1:0] {
    WK_PUSH = 2'd0,
    WK_CTRL = 2'd1,
    WK_ERR  = 2'd2
  } wr_kind_e;

  function automatic logic [63:0] status_word(input logic [8:0] level,
                                              input logic       full,
                                              input logic       empty);
    return {47'd0, level, 6'd0, full, empty};
  endfunction

endpackage

// File: rtl/mmio_uart_ctrl_fifo.sv
// Byte FIFO feeding the UART transmit stream; a push while full is accepted
// only when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [7:0]       data_i,
  input  logic             pop_i,
  output logic [7:0]       data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok_s, pop_ok_s, full_s, empty_s;

  // Accept/advance decisions and next-state pointers and level.
  always_comb begin
    full_s    = (level_q == LVL_W'(DEPTH));
    empty_s   = (level_q == LVL_W'(0));
    pop_ok_s  = pop_i && !empty_s;
    push_ok_s = push_i && (!full_s || pop_ok_s);
    wr_ptr_d  = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      level_q  <= LVL_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is cleared on reset so the exposed head byte reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign level_o = level_q;

endmodule

// File: rtl/mmio_uart_ctrl.sv
// AXI4 slave exposing a UART TX byte FIFO: TXDATA push, STATUS readback and
// a CTRL enable bit, served by a single one-transaction-at-a-time engine.
module mmio_uart_ctrl
  import mmio_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              axi_aw_valid,
  output logic              axi_aw_ready,
  input  logic [ID_W-1:0]   axi_aw_id,
  input  logic [ADDR_W-1:0] axi_aw_addr,
  input  logic [7:0]        axi_aw_len,
  input  logic [2:0]        axi_aw_size,
  input  logic [1:0]        axi_aw_burst,
  input  logic              axi_w_valid,
  output logic              axi_w_ready,
  input  logic [63:0]       axi_w_data,
  input  logic [7:0]        axi_w_strb,
  input  logic              axi_w_last,
  output logic              axi_b_valid,
  input  logic              axi_b_ready,
  output logic [ID_W-1:0]   axi_b_id,
  output logic [1:0]        axi_b_resp,
  input  logic              axi_ar_valid,
  output logic              axi_ar_ready,
  input  logic [ID_W-1:0]   axi_ar_id,
  input  logic [ADDR_W-1:0] axi_ar_addr,
  input  logic [7:0]        axi_ar_len,
  input  logic [2:0]        axi_ar_size,
  input  logic [1:0]        axi_ar_burst,
  output logic              axi_r_valid,
  input  logic              axi_r_ready,
  output logic [ID_W-1:0]   axi_r_id,
  output logic [63:0]       axi_r_data,
  output logic [1:0]        axi_r_resp,
  output logic              axi_r_last,
  output logic [7:0]        uart_axis_tdata,
  output logic              uart_axis_tvalid,
  input  logic              uart_axis_tready
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  eng_state_e       state_q;
  wr_kind_e         wr_kind_q, aw_kind_s;
  logic             live_q, last_wr_q, tx_en_q, tx_en_d;
  logic [ID_W-1:0]  id_q;
  logic [7:0]       beats_q;
  logic             b_valid_q, r_valid_q, r_last_q;
  logic [ID_W-1:0]  b_id_q, r_id_q;
  logic [1:0]       b_resp_q, r_resp_q;
  logic [63:0]      r_data_q;

  logic             idle_s, grant_w_s, grant_r_s;
  logic             tvalid_s, pop_s, push_s, ctrl_wr_s;
  logic             w_push_beat_s, w_ready_s, w_hs_s;
  logic [63:0]      rd_data_s;
  logic [1:0]       rd_resp_s;
  logic [7:0]       fifo_head_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [LVL_W-1:0] fifo_level_s;
  logic             unused_s;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push_s),
    .data_i  (axi_w_data[7:0]),
    .pop_i   (pop_s),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level_s)
  );

  // Arbitration, stream handshake and write-beat qualification.
  always_comb begin
    idle_s        = live_q && (state_q == ST_IDLE);
    grant_w_s     = idle_s && axi_aw_valid && (!axi_ar_valid || !last_wr_q);
    grant_r_s     = idle_s && axi_ar_valid && !grant_w_s;
    tvalid_s      = !fifo_empty_s && tx_en_q;
    pop_s         = tvalid_s && uart_axis_tready;
    w_push_beat_s = (wr_kind_q == WK_PUSH) && axi_w_strb[0];
    // A full FIFO still takes a push when the head leaves in the same cycle.
    w_ready_s     = (state_q == ST_WDATA) && !(w_push_beat_s && fifo_full_s && !pop_s);
    w_hs_s        = axi_w_valid && w_ready_s;
    push_s        = w_hs_s && w_push_beat_s;
    ctrl_wr_s     = w_hs_s && (wr_kind_q == WK_CTRL) && axi_w_strb[0];
    tx_en_d       = ctrl_wr_s ? axi_w_data[0] : tx_en_q;
  end

  // Classify an incoming write address.
  always_comb begin
    aw_kind_s = WK_ERR;
    if (axi_aw_len != 8'd0) begin
      aw_kind_s = WK_ERR;
    end else begin
      case (axi_aw_addr[4:3])
        REG_TXDATA: aw_kind_s = WK_PUSH;
        REG_CTRL:   aw_kind_s = WK_CTRL;
        default:    aw_kind_s = WK_ERR;
      endcase
    end
  end

  // Read payload, snapshotted when the read address is accepted.
  always_comb begin
    rd_data_s = 64'd0;
    rd_resp_s = RESP_SLVERR;
    if (axi_ar_len != 8'd0) begin
      rd_data_s = 64'd0;
      rd_resp_s = RESP_SLVERR;
    end else begin
      case (axi_ar_addr[4:3])
        REG_STATUS: begin
          rd_data_s = status_word(9'(fifo_level_s), fifo_full_s, fifo_empty_s);
          rd_resp_s = RESP_OKAY;
        end
        REG_CTRL: begin
          rd_data_s = {63'd0, tx_en_q};
          rd_resp_s = RESP_OKAY;
        end
        default: begin
          rd_data_s = 64'd0;
          rd_resp_s = RESP_SLVERR;
        end
      endcase
    end
  end

  // Transmit enable register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en_q <= 1'b1;
    end else begin
      tx_en_q <= tx_en_d;
    end
  end

  // Access engine with registered response channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      live_q    <= 1'b0;
      last_wr_q <= 1'b0;
      wr_kind_q <= WK_ERR;
      id_q      <= {ID_W{1'b0}};
      beats_q   <= 8'd0;
      b_valid_q <= 1'b0;
      b_id_q    <= {ID_W{1'b0}};
      b_resp_q  <= 2'b00;
      r_valid_q <= 1'b0;
      r_id_q    <= {ID_W{1'b0}};
      r_data_q  <= 64'd0;
      r_resp_q  <= 2'b00;
      r_last_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (grant_w_s) begin
            id_q      <= axi_aw_id;
            wr_kind_q <= aw_kind_s;
            last_wr_q <= 1'b1;
            state_q   <= ST_WDATA;
          end else if (grant_r_s) begin
            last_wr_q <= 1'b0;
            beats_q   <= axi_ar_len;
            r_valid_q <= 1'b1;
            r_id_q    <= axi_ar_id;
            r_data_q  <= rd_data_s;
            r_resp_q  <= rd_resp_s;
            r_last_q  <= (axi_ar_len == 8'd0);
            state_q   <= ST_RDATA;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WDATA: begin
          if (w_hs_s && axi_w_last) begin
            b_valid_q <= 1'b1;
            b_id_q    <= id_q;
            b_resp_q  <= (wr_kind_q == WK_ERR) ? RESP_SLVERR : RESP_OKAY;
            state_q   <= ST_WRESP;
          end else begin
            state_q <= ST_WDATA;
          end
        end
        ST_WRESP: begin
          if (axi_b_ready) begin
            b_valid_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            state_q <= ST_WRESP;
          end
        end
        ST_RDATA: begin
          if (axi_r_ready && (beats_q == 8'd0)) begin
            r_valid_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (axi_r_ready) begin
            beats_q  <= beats_q - 8'd1;
            r_last_q <= (beats_q == 8'd1);
          end else begin
            state_q <= ST_RDATA;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign axi_aw_ready     = grant_w_s;
  assign axi_ar_ready     = grant_r_s;
  assign axi_w_ready      = w_ready_s;
  assign axi_b_valid      = b_valid_q;
  assign axi_b_id         = b_id_q;
  assign axi_b_resp       = b_resp_q;
  assign axi_r_valid      = r_valid_q;
  assign axi_r_id         = r_id_q;
  assign axi_r_data       = r_data_q;
  assign axi_r_resp       = r_resp_q;
  assign axi_r_last       = r_last_q;
  assign uart_axis_tdata  = fifo_head_s;
  assign uart_axis_tvalid = tvalid_s;

  // Burst attributes and address/data bits outside the register map are ignored.
  assign unused_s = ^{axi_aw_size, axi_aw_burst, axi_ar_size, axi_ar_burst,
                      axi_aw_addr[ADDR_W-1:5], axi_aw_addr[2:0],
                      axi_ar_addr[ADDR_W-1:5], axi_ar_addr[2:0],
                      axi_w_data[63:8], axi_w_strb[7:1]};

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl: register access, FIFO back-pressure,
// TX gating, error responses, arbitration and mid-transaction reset.
module tb_mmio_uart_ctrl;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 31;
  localparam int DEPTH  = 16;

  logic              clk, rst_n;
  logic              axi_aw_valid, axi_aw_ready;
  logic [ID_W-1:0]   axi_aw_id;
  logic [ADDR_W-1:0] axi_aw_addr;
  logic [7:0]        axi_aw_len;
  logic [2:0]        axi_aw_size;
  logic [1:0]        axi_aw_burst;
  logic              axi_w_valid, axi_w_ready;
  logic [63:0]       axi_w_data;
  logic [7:0]        axi_w_strb;
  logic              axi_w_last;
  logic              axi_b_valid, axi_b_ready;
  logic [ID_W-1:0]   axi_b_id;
  logic [1:0]        axi_b_resp;
  logic              axi_ar_valid, axi_ar_ready;
  logic [ID_W-1:0]   axi_ar_id;
  logic [ADDR_W-1:0] axi_ar_addr;
  logic [7:0]        axi_ar_len;
  logic [2:0]        axi_ar_size;
  logic [1:0]        axi_ar_burst;
  logic              axi_r_valid, axi_r_ready;
  logic [ID_W-1:0]   axi_r_id;
  logic [63:0]       axi_r_data;
  logic [1:0]        axi_r_resp;
  logic              axi_r_last;
  logic [7:0]        uart_axis_tdata;
  logic              uart_axis_tvalid, uart_axis_tready;

  int errors = 0;
  int checks = 0;

  logic [7:0]      popped[$];
  int              tvalid_cycles;
  logic [63:0]     rd_data [8];
  logic [1:0]      rd_resp [8];
  logic [ID_W-1:0] rd_id   [8];
  logic            rd_last [8];
  int              nbeats;

  bit              ok, imm;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  mmio_uart_ctrl #(.FIFO_DEPTH(DEPTH), .ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_id(axi_aw_id),
    .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len), .axi_aw_size(axi_aw_size),
    .axi_aw_burst(axi_aw_burst),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
    .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_id(axi_b_id),
    .axi_b_resp(axi_b_resp),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_id(axi_ar_id),
    .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
    .axi_ar_burst(axi_ar_burst),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_id(axi_r_id),
    .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last),
    .uart_axis_tdata(uart_axis_tdata), .uart_axis_tvalid(uart_axis_tvalid),
    .uart_axis_tready(uart_axis_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every byte leaving on the stream and every cycle tvalid is high.
  always @(negedge clk) begin
    if (uart_axis_tvalid) tvalid_cycles++;
    if (uart_axis_tvalid && uart_axis_tready) popped.push_back(uart_axis_tdata);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_phase(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id,
                          input logic [7:0] len, output bit okay);
    axi_aw_addr = a; axi_aw_id = id; axi_aw_len = len; axi_aw_valid = 1'b1;
    okay = 1'b0;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (axi_aw_ready) begin okay = 1'b1; break; end
      step();
    end
    step();
    axi_aw_valid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic last,
                        output bit okay);
    axi_w_data = d; axi_w_strb = s; axi_w_last = last; axi_w_valid = 1'b1;
    okay = 1'b0;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (axi_w_ready) begin okay = 1'b1; break; end
      step();
    end
    step();
    axi_w_valid = 1'b0;
  endtask

  task automatic b_phase(output logic [ID_W-1:0] id, output logic [1:0] resp,
                         output bit okay, output bit now);
    now = axi_b_valid;
    axi_b_ready = 1'b1;
    okay = 1'b0;
    id = '0; resp = 2'b11;
    for (int i = 0; i < 50; i++) begin
      if (axi_b_valid) begin okay = 1'b1; id = axi_b_id; resp = axi_b_resp; break; end
      step();
    end
    step();
    axi_b_ready = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id,
                          input logic [63:0] d, input logic [7:0] s,
                          output logic [ID_W-1:0] rid, output logic [1:0] resp,
                          output bit okay, output bit now);
    bit ok1, ok2, ok3;
    aw_phase(a, id, 8'd0, ok1);
    w_beat(d, s, 1'b1, ok2);
    b_phase(rid, resp, ok3, now);
    okay = ok1 && ok2 && ok3;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id,
                         input logic [7:0] len, output bit now);
    bit got;
    axi_ar_addr = a; axi_ar_id = id; axi_ar_len = len; axi_ar_valid = 1'b1;
    nbeats = 0;
    now = 1'b0;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (axi_ar_ready) break;
      step();
    end
    step();
    axi_ar_valid = 1'b0;
    now = axi_r_valid;
    axi_r_ready = 1'b1;
    for (int n = 0; n <= int'(len) && n < 8; n++) begin
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (axi_r_valid) begin got = 1'b1; break; end
        step();
      end
      if (!got) break;
      rd_data[n] = axi_r_data; rd_resp[n] = axi_r_resp;
      rd_id[n] = axi_r_id; rd_last[n] = axi_r_last;
      nbeats++;
      step();
    end
    axi_r_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    axi_aw_valid = 1'b1; axi_ar_valid = 1'b1; axi_w_valid = 1'b1;
    axi_b_ready = 1'b1; axi_r_ready = 1'b1; uart_axis_tready = 1'b1;
    repeat (3) step();
    checks++;
    if ({axi_aw_ready, axi_w_ready, axi_ar_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b, want 000", {axi_aw_ready, axi_w_ready, axi_ar_ready});
    end
    checks++;
    if ({axi_b_valid, axi_r_valid, uart_axis_tvalid} !== 3'b000) begin
      errors++; $display("FAIL reset_valid: got %b, want 000", {axi_b_valid, axi_r_valid, uart_axis_tvalid});
    end
    checks++;
    if ({axi_b_id, axi_b_resp, axi_r_id, axi_r_resp, axi_r_last, uart_axis_tdata} !== 21'd0) begin
      errors++; $display("FAIL reset_payload: got %h, want 0",
                         {axi_b_id, axi_b_resp, axi_r_id, axi_r_resp, axi_r_last, uart_axis_tdata});
    end
    checks++;
    if (axi_r_data !== 64'd0) begin
      errors++; $display("FAIL reset_rdata: got %h, want 0", axi_r_data);
    end
    axi_aw_valid = 1'b0; axi_ar_valid = 1'b0; axi_w_valid = 1'b0;
    axi_b_ready = 1'b0; axi_r_ready = 1'b0; uart_axis_tready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_same_cycle();
    bit ok1, ok2, ok3;
    uart_axis_tready = 1'b0;
    popped.delete();
    axi_aw_addr = 31'h00; axi_aw_id = 4'd3; axi_aw_len = 8'd0; axi_aw_valid = 1'b1;
    axi_ar_addr = 31'h08; axi_ar_id = 4'd9; axi_ar_len = 8'd0; axi_ar_valid = 1'b1;
    #1;
    checks++;
    if ({axi_aw_ready, axi_ar_ready} !== 2'b10) begin
      errors++; $display("FAIL first_grant: got aw/ar=%b, want 10", {axi_aw_ready, axi_ar_ready});
    end
    aw_phase(31'h00, 4'd3, 8'd0, ok1);
    w_beat(64'h55, 8'h01, 1'b1, ok2);
    b_phase(bid, bresp, ok3, imm);
    checks++;
    if (!(ok1 && ok2 && ok3) || bresp !== 2'b00 || bid !== 4'd3 || !imm) begin
      errors++; $display("FAIL same_cycle_wr: got ok=%0d resp=%b id=%0d imm=%0d, want 1 00 3 1",
                         ok1 && ok2 && ok3, bresp, bid, imm);
    end
    do_read(31'h08, 4'd9, 8'd0, imm);
    checks++;
    if (nbeats !== 1 || rd_data[0] !== 64'h100 || rd_resp[0] !== 2'b00 || rd_id[0] !== 4'd9 ||
        rd_last[0] !== 1'b1 || !imm) begin
      errors++; $display("FAIL same_cycle_status: got beats=%0d data=%h resp=%b id=%0d last=%b imm=%0d, want 1 100 00 9 1 1",
                         nbeats, rd_data[0], rd_resp[0], rd_id[0], rd_last[0], imm);
    end
    uart_axis_tready = 1'b1;
    repeat (3) step();
    uart_axis_tready = 1'b0;
    checks++;
    if (popped.size() !== 1 || popped[0] !== 8'h55) begin
      errors++; $display("FAIL same_cycle_drain: got %0d bytes first=%h, want 1 byte 55", popped.size(), popped[0]);
    end
  endtask

  task automatic test_round_robin();
    do_write(31'h10, 4'd1, 64'h1, 8'h01, bid, bresp, ok, imm);
    axi_aw_addr = 31'h10; axi_aw_id = 4'd2; axi_aw_len = 8'd0; axi_aw_valid = 1'b1;
    axi_ar_addr = 31'h10; axi_ar_id = 4'd4; axi_ar_len = 8'd0; axi_ar_valid = 1'b1;
    #1;
    checks++;
    if ({axi_aw_ready, axi_ar_ready} !== 2'b01) begin
      errors++; $display("FAIL rr_read_turn: got aw/ar=%b, want 01", {axi_aw_ready, axi_ar_ready});
    end
    do_read(31'h10, 4'd4, 8'd0, imm);
    checks++;
    if (rd_data[0] !== 64'h1 || rd_resp[0] !== 2'b00) begin
      errors++; $display("FAIL rr_ctrl_read: got %h/%b, want 1/00", rd_data[0], rd_resp[0]);
    end
    do_write(31'h10, 4'd2, 64'h1, 8'h01, bid, bresp, ok, imm);
    checks++;
    if (!ok || bid !== 4'd2 || bresp !== 2'b00) begin
      errors++; $display("FAIL rr_write_after: got ok=%0d id=%0d resp=%b, want 1 2 00", ok, bid, bresp);
    end
  endtask

  task automatic test_tx_single();
    popped.delete();
    uart_axis_tready = 1'b1;
    tvalid_cycles = 0;
    do_write(31'h00, 4'd5, 64'h41, 8'h01, bid, bresp, ok, imm);
    checks++;
    if (!ok || bresp !== 2'b00 || bid !== 4'd5) begin
      errors++; $display("FAIL tx_single_resp: got ok=%0d resp=%b id=%0d, want 1 00 5", ok, bresp, bid);
    end
    checks++;
    if (!imm) begin
      errors++; $display("FAIL tx_single_blat: got b_valid=0 after w_last, want 1");
    end
    repeat (4) step();
    checks++;
    if (popped.size() !== 1 || popped[0] !== 8'h41) begin
      errors++; $display("FAIL tx_single_data: got %0d bytes first=%h, want 1 byte 41", popped.size(), popped[0]);
    end
    checks++;
    if (tvalid_cycles !== 1) begin
      errors++; $display("FAIL tx_single_pulse: got %0d tvalid cycles, want 1", tvalid_cycles);
    end
    uart_axis_tready = 1'b0;
  endtask

  task automatic test_backpressure();
    int  okcnt;
    bit  stalled, ok1, ok2, ok3, inorder;
    popped.delete();
    uart_axis_tready = 1'b0;
    okcnt = 0;
    for (int i = 0; i < 16; i++) begin
      do_write(31'h00, 4'(i), 64'(i), 8'h01, bid, bresp, ok, imm);
      if (ok && bresp === 2'b00 && bid === 4'(i) && imm) okcnt++;
    end
    checks++;
    if (okcnt !== 16) begin
      errors++; $display("FAIL bp_fill: got %0d OKAY writes, want 16", okcnt);
    end
    aw_phase(31'h00, 4'd7, 8'd0, ok1);
    axi_w_data = 64'd16; axi_w_strb = 8'h01; axi_w_last = 1'b1; axi_w_valid = 1'b1;
    stalled = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (axi_w_ready !== 1'b0) stalled = 1'b0;
      step();
    end
    checks++;
    if (!stalled || !ok1) begin
      errors++; $display("FAIL bp_stall: got stalled=%0d aw_ok=%0d, want 1 1", stalled, ok1);
    end
    uart_axis_tready = 1'b1;
    ok2 = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (axi_w_ready) begin ok2 = 1'b1; break; end
      step();
    end
    step();
    axi_w_valid = 1'b0;
    uart_axis_tready = 1'b0;
    b_phase(bid, bresp, ok3, imm);
    checks++;
    if (!ok2 || !ok3 || bresp !== 2'b00 || bid !== 4'd7) begin
      errors++; $display("FAIL bp_release: got w_ok=%0d b_ok=%0d resp=%b id=%0d, want 1 1 00 7", ok2, ok3, bresp, bid);
    end
    do_read(31'h08, 4'd0, 8'd0, imm);
    checks++;
    if (rd_data[0] !== 64'h1002) begin
      errors++; $display("FAIL bp_full_status: got %h, want 1002", rd_data[0]);
    end
    uart_axis_tready = 1'b1;
    repeat (25) step();
    uart_axis_tready = 1'b0;
    inorder = (popped.size() == 17);
    for (int k = 0; k < popped.size() && k < 17; k++) begin
      if (popped[k] !== 8'(k)) inorder = 1'b0;
    end
    checks++;
    if (!inorder) begin
      errors++; $display("FAIL bp_order: got %0d bytes (or wrong order), want 17 bytes 0..16", popped.size());
    end
  endtask

  task automatic test_ctrl_gate();
    popped.delete();
    uart_axis_tready = 1'b1;
    do_write(31'h10, 4'd1, 64'h0, 8'h01, bid, bresp, ok, imm);
    checks++;
    if (!ok || bresp !== 2'b00) begin
      errors++; $display("FAIL ctrl_off_resp: got ok=%0d resp=%b, want 1 00", ok, bresp);
    end
    tvalid_cycles = 0;
    do_write(31'h00, 4'd1, 64'hA1, 8'h01, bid, bresp, ok, imm);
    do_write(31'h00, 4'd1, 64'hA2, 8'h01, bid, bresp, ok, imm);
    do_write(31'h00, 4'd1, 64'hA3, 8'h01, bid, bresp, ok, imm);
    repeat (3) step();
    checks++;
    if (tvalid_cycles !== 0 || popped.size() !== 0) begin
      errors++; $display("FAIL ctrl_gated: got tvalid_cycles=%0d popped=%0d, want 0 0", tvalid_cycles, popped.size());
    end
    do_read(31'h08, 4'd2, 8'd0, imm);
    checks++;
    if (rd_data[0] !== 64'h300 || rd_resp[0] !== 2'b00) begin
      errors++; $display("FAIL ctrl_level3: got %h/%b, want 300/00", rd_data[0], rd_resp[0]);
    end
    do_read(31'h10, 4'd2, 8'd0, imm);
    checks++;
    if (rd_data[0] !== 64'h0) begin
      errors++; $display("FAIL ctrl_read0: got %h, want 0", rd_data[0]);
    end
    do_write(31'h10, 4'd1, 64'h1, 8'h01, bid, bresp, ok, imm);
    repeat (8) step();
    checks++;
    if (popped.size() !== 3 || popped[0] !== 8'hA1 || popped[1] !== 8'hA2 || popped[2] !== 8'hA3) begin
      errors++; $display("FAIL ctrl_drain: got %0d bytes %h %h %h, want A1 A2 A3",
                         popped.size(), popped[0], popped[1], popped[2]);
    end
  endtask

  task automatic test_errors();
    bit burst_ok, ok1, ok2, ok3, ok4;
    popped.delete();
    uart_axis_tready = 1'b1;
    do_read(31'h10, 4'd6, 8'd3, imm);
    burst_ok = (nbeats == 4);
    for (int n = 0; n < nbeats; n++) begin
      if (rd_data[n] !== 64'd0 || rd_resp[n] !== 2'b10 || rd_id[n] !== 4'd6 ||
          rd_last[n] !== (n == 3)) burst_ok = 1'b0;
    end
    checks++;
    if (!burst_ok) begin
      errors++; $display("FAIL err_rd_burst: got %0d beats last=%b resp=%b, want 4 beats SLVERR last on 4",
                         nbeats, rd_last[3], rd_resp[0]);
    end
    checks++;
    if (axi_r_valid !== 1'b0) begin
      errors++; $display("FAIL err_rd_extra: got r_valid=1 after 4 beats, want 0");
    end
    do_write(31'h08, 4'd1, 64'hFF, 8'h01, bid, bresp, ok, imm);
    checks++;
    if (bresp !== 2'b10) begin
      errors++; $display("FAIL err_wr_status: got %b, want 10", bresp);
    end
    do_write(31'h18, 4'd1, 64'hFF, 8'h01, bid, bresp, ok, imm);
    checks++;
    if (bresp !== 2'b10) begin
      errors++; $display("FAIL err_wr_unmapped: got %b, want 10", bresp);
    end
    do_read(31'h00, 4'd3, 8'd0, imm);
    checks++;
    if (rd_data[0] !== 64'd0 || rd_resp[0] !== 2'b10 || rd_last[0] !== 1'b1) begin
      errors++; $display("FAIL err_rd_txdata: got %h/%b/%b, want 0/10/1", rd_data[0], rd_resp[0], rd_last[0]);
    end
    do_write(31'h00, 4'd1, 64'h99, 8'h00, bid, bresp, ok, imm);
    checks++;
    if (bresp !== 2'b00) begin
      errors++; $display("FAIL err_strb0_resp: got %b, want 00", bresp);
    end
    aw_phase(31'h00, 4'd8, 8'd1, ok1);
    w_beat(64'hAA, 8'h01, 1'b0, ok2);
    w_beat(64'hBB, 8'h01, 1'b1, ok3);
    b_phase(bid, bresp, ok4, imm);
    checks++;
    if (!(ok1 && ok2 && ok3 && ok4) || bresp !== 2'b10 || bid !== 4'd8) begin
      errors++; $display("FAIL err_wr_burst: got ok=%0d resp=%b id=%0d, want 1 10 8",
                         ok1 && ok2 && ok3 && ok4, bresp, bid);
    end
    repeat (4) step();
    checks++;
    if (popped.size() !== 0) begin
      errors++; $display("FAIL err_no_push: got %0d bytes, want 0", popped.size());
    end
    do_read(31'h108, 4'd3, 8'd0, imm);
    checks++;
    if (rd_data[0] !== 64'h1 || rd_resp[0] !== 2'b00) begin
      errors++; $display("FAIL err_decode_alias: got %h/%b, want 1/00", rd_data[0], rd_resp[0]);
    end
    uart_axis_tready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok1, saw_b;
    uart_axis_tready = 1'b0;
    do_write(31'h10, 4'd1, 64'h0, 8'h01, bid, bresp, ok, imm);
    for (int i = 0; i < 5; i++) begin
      do_write(31'h00, 4'd1, 64'(8'h10 + i), 8'h01, bid, bresp, ok, imm);
    end
    aw_phase(31'h00, 4'd2, 8'd0, ok1);
    #2;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    saw_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (axi_b_valid) saw_b = 1'b1;
      step();
    end
    checks++;
    if (saw_b || !ok1) begin
      errors++; $display("FAIL rst_mid_nob: got b_valid seen=%0d aw_ok=%0d, want 0 1", saw_b, ok1);
    end
    do_read(31'h08, 4'd1, 8'd0, imm);
    checks++;
    if (rd_data[0] !== 64'h1) begin
      errors++; $display("FAIL rst_mid_status: got %h, want 1", rd_data[0]);
    end
    do_read(31'h10, 4'd1, 8'd0, imm);
    checks++;
    if (rd_data[0] !== 64'h1) begin
      errors++; $display("FAIL rst_mid_txen: got %h, want 1", rd_data[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    axi_aw_valid = 1'b0; axi_aw_id = '0; axi_aw_addr = '0; axi_aw_len = 8'd0;
    axi_aw_size = 3'd3; axi_aw_burst = 2'b01;
    axi_w_valid = 1'b0; axi_w_data = 64'd0; axi_w_strb = 8'h00; axi_w_last = 1'b0;
    axi_b_ready = 1'b0;
    axi_ar_valid = 1'b0; axi_ar_id = '0; axi_ar_addr = '0; axi_ar_len = 8'd0;
    axi_ar_size = 3'd3; axi_ar_burst = 2'b01;
    axi_r_ready = 1'b0; uart_axis_tready = 1'b0;
    tvalid_cycles = 0;
    test_reset();
    test_same_cycle();
    test_round_robin();
    test_tx_single();
    test_backpressure();
    test_ctrl_gate();
    test_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_ctrl.md
MMIO_UART_CTRL -- requirements
Module: mmio_uart_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, TX FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-003 SHALL have parameter ADDR_W, default 31, AXI address width.
REQ-004 SHALL have one clock and an asynchronous active-low reset (clk, rst_n); every other signal is synchronous to clk.
REQ-005 SHALL have ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- axi_aw_valid/ready  in/out  1  write-address handshake
- axi_aw_id  in  ID_W  write ID
- axi_aw_addr  in  ADDR_W  write address
- axi_aw_len  in  8  beats-1
- axi_aw_size  in  3  beat size
- axi_aw_burst  in  2  burst type
- axi_w_valid/ready  in/out  1  write-data handshake
- axi_w_data  in  64  write data
- axi_w_strb  in  8  byte strobes
- axi_w_last  in  1  last beat
- axi_b_valid/ready  out/in  1  write-response handshake
- axi_b_id  out  ID_W  response ID
- axi_b_resp  out  2  response code
- axi_ar_valid/ready  in/out  1  read-address handshake
- axi_ar_id  in  ID_W  read ID
- axi_ar_addr  in  ADDR_W  read address
- axi_ar_len  in  8  beats-1
- axi_ar_size  in  3  beat size
- axi_ar_burst  in  2  burst type
- axi_r_valid/ready  out/in  1  read-data handshake
- axi_r_id  out  ID_W  read ID
- axi_r_data  out  64  read data
- axi_r_resp  out  2  response code
- axi_r_last  out  1  last beat
- uart_axis_tdata  out  8  TX byte
- uart_axis_tvalid/tready  out/in  1  TX stream handshake

Function
REQ-006 SHALL decode addr[4:3] only: 0 TXDATA (W), 1 STATUS (R), 2 CTRL (R/W); 3 is unmapped.
REQ-007 SHALL have a single access engine with states IDLE, WDATA, WRESP, RDATA, so at most one transaction is in flight.
REQ-008 In IDLE, with only aw_valid high, SHALL assert aw_ready, capture id/addr/len, and go to WDATA.
REQ-009 In IDLE, with only ar_valid high, SHALL assert ar_ready, capture id/addr/len, and go to RDATA.
REQ-010 In IDLE, with aw_valid and ar_valid both high, SHALL grant the channel not granted last (round-robin); after reset, write wins first.
REQ-011 In WDATA, SHALL accept beats with w_ready; on the w_last handshake SHALL go to WRESP.
REQ-012 A single-beat TXDATA write with w_strb[0]=1 SHALL push w_data[7:0] into the FIFO.
REQ-013 While the FIFO is full and the write is a push, w_ready SHALL be held low (back-pressure, no drop).
REQ-014 A single-beat CTRL write with strb[0]=1 SHALL set tx_en from w_data[0].
REQ-015 A TXDATA or CTRL write with strb[0]=0 SHALL complete as OKAY with no effect.
REQ-016 Writes to STATUS or unmapped addresses, and any write with len!=0, SHALL consume all beats without effect and respond SLVERR (2'b10).
REQ-017 In WRESP, SHALL drive b_valid=1 with the captured id; on b_ready SHALL go to IDLE.
REQ-018 In RDATA, SHALL return len+1 beats with the captured id and r_last on the final beat.
REQ-019 Read data:
- STATUS: {47'b0, level[8:0], 6'b0, full, empty}.
- CTRL: {63'b0, tx_en}.
- Resp OKAY.
REQ-020 Reads of TXDATA or unmapped addresses, and reads with len!=0, SHALL return data 0 with SLVERR on every beat.
REQ-021 uart_axis_tvalid SHALL equal (FIFO not empty && tx_en), and tdata SHALL be the FIFO head.
REQ-022 The FIFO SHALL pop on tvalid&&tready.
REQ-023 A simultaneous push and pop SHALL leave level unchanged, including at full.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; level SHALL range 0..FIFO_DEPTH.
REQ-025 Write latency: b_valid SHALL assert the cycle after the w_last handshake.
REQ-026 Read latency: r_valid SHALL assert the cycle after the ar handshake.
REQ-027 b/r valid and payload SHALL stay stable until the matching ready.

Reset
REQ-028 On rst_n low, the block SHALL asynchronously enter IDLE and set tx_en=1, the FIFO empty, and the round-robin pointer to write.
REQ-029 During reset, all ready/valid outputs SHALL be 0, and b_id, b_resp, r_id, r_data, r_resp, r_last and uart_axis_tdata SHALL be 0.
REQ-030 On a mid-transaction reset, the in-flight transaction and FIFO contents SHALL be discarded with no response issued.

Structure
REQ-031 Package mmio_uart_pkg SHALL hold the register offsets, the OKAY/SLVERR codes and the engine-state enum.
REQ-032 The FIFO SHALL be sub-module uart_tx_fifo (push/pop/full/empty/level).

Verification
REQ-033 Write 0x41 to TXDATA, tready=1: b_resp=OKAY, id echoed, and tdata=0x41 with tvalid pulsing for one cycle.
REQ-034 tready=0, 17 TXDATA writes with depth 16: 16 OKAY responses, the 17th write stalls on w_ready=0, and releasing tready completes it.
REQ-035 Same-cycle AW (TXDATA) and AR (STATUS) after reset: write served first, then STATUS reads level=1, empty=0.
REQ-036 CTRL write 0 then push 3 bytes: tvalid stays 0 and STATUS level=3; CTRL write 1 drains 3 bytes in order.
REQ-037 Read burst len=3 to CTRL: 4 beats of data 0 with SLVERR and r_last on beat 4.
REQ-038 Assert rst_n low in WDATA with the FIFO holding 5 bytes: after release, STATUS reads empty=1, level=0, and no b_valid appears.
